// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES key-expansion engine.
//   - key_len encodings (128 / 192 / 256 / reserved)
//   - Nk / Nr lookup and total schedule word count
//   - round-constant seed, GF(2^8) reduction constant and xtime()
//   - expander FSM state type
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam logic [1:0] KEY_LEN_128  = 2'd0;
  localparam logic [1:0] KEY_LEN_192  = 2'd1;
  localparam logic [1:0] KEY_LEN_256  = 2'd2;
  localparam logic [1:0] KEY_LEN_RSVD = 2'd3;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef enum logic {
    ST_IDLE,
    ST_EXPAND
  } state_t;

  // Number of 32-bit words in the cipher key.
  function automatic logic [3:0] nk_of(input logic [1:0] key_len);
    case (key_len)
      KEY_LEN_128: return 4'd4;
      KEY_LEN_192: return 4'd6;
      KEY_LEN_256: return 4'd8;
      default:     return 4'd4;
    endcase
  endfunction

  // Number of rounds; always Nk + 6.
  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    return nk_of(key_len) + 4'd6;
  endfunction

  // Words in the full schedule: 4 * (Nr + 1).
  function automatic logic [5:0] total_words(input logic [1:0] key_len);
    return {nr_of(key_len) + 4'd1, 2'b00};
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Four parallel AES S-boxes applied to one 32-bit word (SubWord).
// Each byte is the affine transform of its multiplicative inverse in GF(2^8);
// the inverse is formed as x^254 with a square-and-multiply chain.
// Ports:
//   sboxw      in  32  input word
//   new_sboxw  out 32  byte-wise substituted word
// -----------------------------------------------------------------------------
module aes_sbox
  import aes_pkg::*;
(
  input  logic [31:0] sboxw,
  output logic [31:0] new_sboxw
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? RCON_POLY : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(x, x);
    acc = sq;
    for (int k = 0; k < 6; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign new_sboxw[8*gi +: 8] = sbox_byte(sboxw[8*gi +: 8]);
    end
  endgenerate

endmodule

// File: rtl/aes_key_expander.sv
// -----------------------------------------------------------------------------
// aes_key_expander
// Sequential AES key schedule. Accepts a 128/192/256-bit key, generates one
// schedule word per cycle through one shared S-box and streams the Nr+1 round
// keys over a valid/ready interface with backpressure.
// Ports:
//   clk       in   1    clock, rising edge
//   rst_n     in   1    asynchronous active-low reset
//   start     in   1    expansion request, accepted when start && ready
//   ready     out  1    high only in IDLE
//   key_len   in   2    0=AES-128 1=AES-192 2=AES-256 3=reserved
//   key_in    in   MAX_KEY_BITS  left-aligned cipher key
//   rk_valid  out  1    round key available
//   rk_ready  in   1    consumer accepts round key
//   rk_data   out  128  round key {w[4k],w[4k+1],w[4k+2],w[4k+3]}
//   rk_index  out  4    round key number k
//   rk_last   out  1    marks k == Nr
//   key_err   out  1    one-cycle pulse for an unsupported key_len
//   busy      out  1    high outside IDLE
// -----------------------------------------------------------------------------
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    ready,
  input  logic [1:0]              key_len,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic [127:0]            rk_data,
  output logic [3:0]              rk_index,
  output logic                    rk_last,
  output logic                    key_err,
  output logic                    busy
);

  state_t      state_reg;
  // win_reg[k] holds w[i-1-k]: the eight most recently produced words.
  logic [31:0] win_reg [8];
  logic [5:0]  word_i_reg;   // index of next word to generate
  logic [2:0]  pos_reg;      // word_i_reg mod Nk
  logic [3:0]  grp_reg;      // next round key to capture
  logic [7:0]  rcon_reg;
  logic [3:0]  nk_reg;
  logic [3:0]  nr_reg;
  logic [5:0]  total_reg;

  // Key padded to 256 bits so word extraction is independent of MAX_KEY_BITS.
  logic [255:0] key_full;
  logic [31:0]  key_words [8];
  logic [3:0]   req_nk;
  logic         len_ok;

  assign key_full = 256'(key_in) << (256 - MAX_KEY_BITS);
  assign req_nk   = nk_of(key_len);
  assign len_ok   = (key_len != KEY_LEN_RSVD) && ((32 * int'(req_nk)) <= MAX_KEY_BITS);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_key_words
      assign key_words[gi] = key_full[255 - 32*gi -: 32];
    end
  endgenerate

  // Next-word datapath; temp = w[i-1] = win_reg[0], w[i-Nk] = win_reg[Nk-1].
  logic [31:0] sbox_in;
  logic [31:0] sbox_out;
  logic [31:0] temp_mix;
  logic [31:0] new_word;

  assign sbox_in = (pos_reg == 3'd0) ? {win_reg[0][23:0], win_reg[0][31:24]} : win_reg[0];

  aes_sbox u_sbox (
    .sboxw     (sbox_in),
    .new_sboxw (sbox_out)
  );

  always_comb begin
    temp_mix = win_reg[0];
    if (pos_reg == 3'd0) begin
      temp_mix = sbox_out ^ {rcon_reg, 24'h000000};
    end else if (nk_reg == 4'd8 && pos_reg == 3'd4) begin
      temp_mix = sbox_out;
    end
    new_word = win_reg[3'(nk_reg - 4'd1)] ^ temp_mix;
  end

  // Generation is held back once word 4g+8 would push w[4g] out of the window.
  logic [6:0] word_i7;
  logic [6:0] grp_base;
  logic       gen;
  logic       grp_avail;
  logic       xfer;
  logic       capture;

  assign word_i7   = {1'b0, word_i_reg};
  assign grp_base  = {1'b0, grp_reg, 2'b00};
  assign gen       = (state_reg == ST_EXPAND) && (word_i7 <= grp_base + 7'd7) &&
                     (word_i_reg < total_reg);
  // Last word of the group already exists, or is being produced this edge.
  assign grp_avail = (grp_reg <= nr_reg) &&
                     ((word_i7 > grp_base + 7'd3) || (gen && word_i7 == grp_base + 7'd3));
  assign xfer      = rk_valid && rk_ready;
  assign capture   = (state_reg == ST_EXPAND) && (!rk_valid || xfer) && grp_avail;

  // ext[j] = w[i-j]: new word in slot 0 then the window, so word 4g+m is found
  // at ext[i-4g-m] whether or not the last group word is being forwarded.
  logic [31:0]  ext [9];
  logic [3:0]   grp_off;
  logic [127:0] grp_data;

  always_comb begin
    ext[0] = new_word;
    for (int k = 0; k < 8; k++) begin
      ext[k+1] = win_reg[k];
    end
    grp_off  = 4'(word_i7 - grp_base);
    grp_data = '0;
    for (int m = 0; m < 4; m++) begin
      grp_data[127 - 32*m -: 32] = ext[grp_off - 4'(m)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      ready      <= 1'b1;
      busy       <= 1'b0;
      rk_valid   <= 1'b0;
      rk_last    <= 1'b0;
      key_err    <= 1'b0;
      rk_data    <= '0;
      rk_index   <= '0;
      rcon_reg   <= RCON_INIT;
      word_i_reg <= '0;
      pos_reg    <= '0;
      grp_reg    <= '0;
      nk_reg     <= 4'd4;
      nr_reg     <= 4'd10;
      total_reg  <= 6'd44;
      for (int k = 0; k < 8; k++) begin
        win_reg[k] <= '0;
      end
    end else begin
      key_err <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (!len_ok) begin
              key_err <= 1'b1;
            end else begin
              state_reg  <= ST_EXPAND;
              ready      <= 1'b0;
              busy       <= 1'b1;
              nk_reg     <= req_nk;
              nr_reg     <= nr_of(key_len);
              total_reg  <= total_words(key_len);
              word_i_reg <= 6'(req_nk);
              pos_reg    <= '0;
              rcon_reg   <= RCON_INIT;
              grp_reg    <= 4'd1;
              for (int k = 0; k < 8; k++) begin
                win_reg[k] <= key_words[3'(req_nk - 4'(k) - 4'd1)];
              end
              // Round key 0 is the key itself.
              rk_data  <= key_full[255:128];
              rk_index <= 4'd0;
              rk_last  <= 1'b0;
              rk_valid <= 1'b1;
            end
          end
        end

        ST_EXPAND: begin
          if (gen) begin
            for (int k = 7; k > 0; k--) begin
              win_reg[k] <= win_reg[k-1];
            end
            win_reg[0] <= new_word;
            word_i_reg <= word_i_reg + 6'd1;
            pos_reg    <= (pos_reg == 3'(nk_reg - 4'd1)) ? 3'd0 : pos_reg + 3'd1;
            if (pos_reg == 3'd0) begin
              rcon_reg <= xtime(rcon_reg);
            end
          end

          if (capture) begin
            rk_data  <= grp_data;
            rk_index <= grp_reg;
            rk_last  <= (grp_reg == nr_reg);
            rk_valid <= 1'b1;
            grp_reg  <= grp_reg + 4'd1;
          end else if (xfer) begin
            rk_valid <= 1'b0;
            if (rk_last) begin
              rk_last   <= 1'b0;
              state_reg <= ST_IDLE;
              ready     <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
module tb_aes_key_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start;
  logic         ready;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         rk_last;
  logic         key_err;
  logic         busy;

  logic         s_start;
  logic         s_ready;
  logic [1:0]   s_key_len;
  logic [127:0] s_key_in;
  logic         s_rk_valid;
  logic         s_rk_ready;
  logic [127:0] s_rk_data;
  logic [3:0]   s_rk_index;
  logic         s_rk_last;
  logic         s_key_err;
  logic         s_busy;

  aes_key_expander #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .key_len(key_len),
    .key_in(key_in), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_index(rk_index), .rk_last(rk_last), .key_err(key_err), .busy(busy)
  );

  aes_key_expander #(.MAX_KEY_BITS(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .ready(s_ready), .key_len(s_key_len),
    .key_in(s_key_in), .rk_valid(s_rk_valid), .rk_ready(s_rk_ready), .rk_data(s_rk_data),
    .rk_index(s_rk_index), .rk_last(s_rk_last), .key_err(s_key_err), .busy(s_busy)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_rk   [15];
  logic [127:0] got_rk   [15];
  logic [3:0]   got_idx  [15];
  logic         got_last [15];
  int           got_cyc  [15];
  int           n_got;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int x; int y; int r;
    x = int'(a); y = int'(b); r = 0;
    while (y != 0) begin
      if ((y & 1) != 0) r = r ^ x;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 283;
      y = y >> 1;
    end
    return r[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[a] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
  endfunction

  function automatic int nr_for(input logic [1:0] len);
    return (len == 2'd0) ? 10 : (len == 2'd1) ? 12 : 14;
  endfunction

  task automatic model_expand(input logic [255:0] key, input logic [1:0] len);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rc [11];
    int nk; int nr;
    rc[0] = 8'h00; rc[1] = 8'h01; rc[2] = 8'h02; rc[3] = 8'h04; rc[4] = 8'h08;
    rc[5] = 8'h10; rc[6] = 8'h20; rc[7] = 8'h40; rc[8] = 8'h80; rc[9] = 8'h1b; rc[10] = 8'h36;
    nr = nr_for(len);
    nk = nr - 6;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      temp = w[i-1];
      if (i % nk == 0)
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc[i/nk], 24'h0};
      else if (nk == 8 && i % nk == 4)
        temp = sub_word(temp);
      w[i] = w[i-nk] ^ temp;
    end
    for (int k = 0; k <= nr; k++) exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // ---------------- full expansion scenario ----------------
  // mode 0: rk_ready held high; 1: random with 20 low cycles; 2: random.
  // In modes 1/2 start, key_in and key_len are scrambled while busy.
  task automatic run_key(input logic [255:0] key, input logic [1:0] len, input int mode);
    int cyc; int nr; bit done;
    logic prev_stall; logic [127:0] prev_data; logic [3:0] prev_idx; logic prev_last;
    for (int k = 0; k < 15; k++) begin
      got_rk[k] = '0; got_idx[k] = '0; got_last[k] = 1'b0; got_cyc[k] = -1;
    end
    n_got = 0;
    nr = nr_for(len);
    @(negedge clk);
    start = 1'b1; key_in = key; key_len = len; rk_ready = (mode == 0);
    @(posedge clk);
    cyc = 0; done = 0; prev_stall = 1'b0;
    prev_data = '0; prev_idx = '0; prev_last = 1'b0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (mode == 0) start = 1'b0;
      else begin
        start   = 1'($urandom_range(0, 1));
        key_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        key_len = 2'($urandom_range(0, 3));
      end
      if (prev_stall) begin
        checks++;
        if (rk_valid !== 1'b1 || rk_data !== prev_data || rk_index !== prev_idx || rk_last !== prev_last) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got v=%b idx=%0d last=%b data=%h exp v=1 idx=%0d last=%b data=%h",
                   cyc, rk_valid, rk_index, rk_last, rk_data, prev_idx, prev_last, prev_data);
        end
      end
      if (mode == 0) rk_ready = 1'b1;
      else if (mode == 1 && cyc >= 10 && cyc < 30) rk_ready = 1'b0;
      else rk_ready = 1'($urandom_range(0, 1));
      if (rk_valid && rk_ready) begin
        got_rk[n_got] = rk_data; got_idx[n_got] = rk_index;
        got_last[n_got] = rk_last; got_cyc[n_got] = cyc;
        n_got++;
        if (rk_last || n_got == 15) begin
          done = 1;
          start = 1'b0;
        end
      end
      prev_stall = rk_valid && !rk_ready;
      prev_data = rk_data; prev_idx = rk_index; prev_last = rk_last;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL run_timeout got=%0d keys exp=%0d keys", n_got, nr + 1);
    end
    @(negedge clk);
    start = 1'b0; rk_ready = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
      failures++;
      $display("FAIL ready_return got ready=%b busy=%b valid=%b exp 1 0 0", ready, busy, rk_valid);
    end
    model_expand(key, len);
    checks++;
    if (n_got != nr + 1) begin
      failures++;
      $display("FAIL key_count got=%0d exp=%0d", n_got, nr + 1);
    end
    for (int k = 0; k <= nr && k < n_got; k++) begin
      checks++;
      if (got_rk[k] !== exp_rk[k] || got_idx[k] !== 4'(k) || got_last[k] !== (k == nr)) begin
        failures++;
        $display("FAIL rk%0d got idx=%0d last=%b data=%h exp idx=%0d last=%b data=%h",
                 k, got_idx[k], got_last[k], got_rk[k], k, (k == nr), exp_rk[k]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0 || rk_last !== 1'b0 ||
        key_err !== 1'b0 || rk_data !== 128'h0 || rk_index !== 4'h0) begin
      failures++;
      $display("FAIL reset_state got ready=%b busy=%b v=%b last=%b err=%b idx=%0d data=%h exp 1 0 0 0 0 0 0",
               ready, busy, rk_valid, rk_last, key_err, rk_index, rk_data);
    end
  endtask

  task automatic test_aes128_vector();
    run_key(K128, 2'd0, 0);
    checks++;
    if (got_rk[0] !== K128[255:128] || got_cyc[0] !== 1) begin
      failures++;
      $display("FAIL aes128_rk0 got=%h cyc=%0d exp=%h cyc=1", got_rk[0], got_cyc[0], K128[255:128]);
    end
    checks++;
    if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605 || got_cyc[1] !== 5) begin
      failures++;
      $display("FAIL aes128_rk1 got=%h cyc=%0d exp=a0fafe1788542cb123a339392a6c7605 cyc=5", got_rk[1], got_cyc[1]);
    end
    checks++;
    if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || got_last[10] !== 1'b1 || got_cyc[10] !== 41) begin
      failures++;
      $display("FAIL aes128_rk10 got=%h last=%b cyc=%0d exp=d014f9a8c9ee2589e13f0cc8b6630ca6 last=1 cyc=41",
               got_rk[10], got_last[10], got_cyc[10]);
    end
    for (int k = 2; k < 10; k++) begin
      checks++;
      if (got_cyc[k] !== 4*k + 1) begin
        failures++;
        $display("FAIL aes128_timing rk%0d got cyc=%0d exp cyc=%0d", k, got_cyc[k], 4*k + 1);
      end
    end
  endtask

  task automatic test_aes192_vector();
    run_key(K192, 2'd1, 0);
    checks++;
    if (got_rk[1] !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5) begin
      failures++;
      $display("FAIL aes192_rk1 got=%h exp=62f8ead2522c6b7bfe0c91f72402f5a5", got_rk[1]);
    end
    checks++;
    if (got_rk[12] !== 128'he98ba06f448c773c8ecc720401002202 || got_last[12] !== 1'b1) begin
      failures++;
      $display("FAIL aes192_rk12 got=%h last=%b exp=e98ba06f448c773c8ecc720401002202 last=1", got_rk[12], got_last[12]);
    end
  endtask

  task automatic test_aes256_vector();
    run_key(K256, 2'd2, 0);
    checks++;
    if (got_rk[0] !== K256[255:128] || got_cyc[0] !== 1) begin
      failures++;
      $display("FAIL aes256_rk0 got=%h cyc=%0d exp=%h cyc=1", got_rk[0], got_cyc[0], K256[255:128]);
    end
    checks++;
    if (got_rk[1] !== 128'h1f352c073b6108d72d9810a30914dff4 || got_cyc[1] !== 2) begin
      failures++;
      $display("FAIL aes256_rk1 got=%h cyc=%0d exp=1f352c073b6108d72d9810a30914dff4 cyc=2", got_rk[1], got_cyc[1]);
    end
    checks++;
    if (got_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e || got_last[14] !== 1'b1) begin
      failures++;
      $display("FAIL aes256_rk14 got=%h last=%b exp=fe4890d1e6188d0b046df344706c631e last=1", got_rk[14], got_last[14]);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] rkey;
    run_key(K128, 2'd0, 1);
    for (int n = 0; n < 6; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_key(rkey, 2'(n % 3), (n < 3) ? 1 : 2);
    end
  endtask

  task automatic test_key_err();
    logic [127:0] k;
    // Reserved encoding on the full-width engine.
    @(negedge clk); start = 1'b1; key_len = 2'd3; key_in = K256;
    @(negedge clk); start = 1'b0;
    checks++;
    if (key_err !== 1'b1 || ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL err_rsvd got err=%b ready=%b v=%b busy=%b exp 1 1 0 0", key_err, ready, rk_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (key_err !== 1'b0 || rk_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse got err=%b v=%b exp 0 0", key_err, rk_valid);
    end
    // Key sizes beyond a 128-bit engine.
    for (int l = 1; l <= 3; l++) begin
      @(negedge clk); s_start = 1'b1; s_key_len = 2'(l); s_key_in = K128[255:128];
      @(negedge clk); s_start = 1'b0;
      checks++;
      if (s_key_err !== 1'b1 || s_ready !== 1'b1 || s_rk_valid !== 1'b0) begin
        failures++;
        $display("FAIL err128_len%0d got err=%b ready=%b v=%b exp 1 1 0", l, s_key_err, s_ready, s_rk_valid);
      end
      @(negedge clk);
      checks++;
      if (s_key_err !== 1'b0 || s_busy !== 1'b0) begin
        failures++;
        $display("FAIL err128_pulse%0d got err=%b busy=%b exp 0 0", l, s_key_err, s_busy);
      end
    end
    // AES-128 still accepted by the narrow engine.
    k = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); s_start = 1'b1; s_key_len = 2'd0; s_key_in = k;
    @(negedge clk); s_start = 1'b0;
    checks++;
    if (s_rk_valid !== 1'b1 || s_rk_data !== k || s_rk_index !== 4'd0 || s_key_err !== 1'b0) begin
      failures++;
      $display("FAIL narrow_accept got v=%b idx=%0d err=%b data=%h exp v=1 idx=0 err=0 data=%h",
               s_rk_valid, s_rk_index, s_key_err, s_rk_data, k);
    end
    for (int c = 0; c < 200 && s_busy; c++) @(negedge clk);
    checks++;
    if (s_busy !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL narrow_drain got busy=%b ready=%b exp 0 1", s_busy, s_ready);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    found = 0;
    @(negedge clk); start = 1'b1; key_in = K128; key_len = 2'd0; rk_ready = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rk_valid && rk_index == 4'd5) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_round5 got=0 exp=1");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0 || rk_last !== 1'b0 ||
        key_err !== 1'b0 || rk_data !== 128'h0 || rk_index !== 4'h0) begin
      failures++;
      $display("FAIL async_reset got ready=%b busy=%b v=%b last=%b err=%b idx=%0d data=%h exp 1 0 0 0 0 0 0",
               ready, busy, rk_valid, rk_last, key_err, rk_index, rk_data);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (rk_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_quiet cyc=%0d got v=%b busy=%b exp 0 0", c, rk_valid, busy);
      end
    end
    run_key(K128, 2'd0, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; key_len = 2'd0; key_in = '0; rk_ready = 1'b0;
    s_start = 1'b0; s_key_len = 2'd0; s_key_in = '0; s_rk_ready = 1'b1;
    build_sbox();
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_aes128_vector();
    test_aes192_vector();
    test_aes256_vector();
    test_backpressure();
    test_key_err();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
